alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational integer ALU between two requesters: the pipelined CPU execute stage and the crypto core.
//  Requests carry operands and a 4-bit ALUCtrl code and use a valid/ready handshake. Each result is registered into a
//  per-requester one-entry response slot, so latency is 1 cycle. Arbitration is CPU-priority with a bounded crypto wait.
//  Idle operand isolation: ALU inputs hold their last issued values to save toggle power.
// PARAMETERS
//  XLEN      32  operand/result width
//  CTRL_W    4   ALUCtrl width (codes in alu_defs.vh)
//  MAX_WAIT  4   max consecutive cycles crypto may wait while valid before a forced grant (>=1)
// PORTS
//  clk              in   1       single clock, rising edge
//  rst              in   1       synchronous, active-high reset
//  cpu_req_valid    in   1       CPU request present
//  cpu_req_ready    out  1       CPU request accepted this cycle when valid&ready
//  cpu_op_a/b       in   XLEN    CPU operands
//  cpu_alu_ctrl     in   CTRL_W  CPU ALU operation
//  cpu_rsp_valid    out  1       CPU result slot full
//  cpu_rsp_data     out  XLEN    CPU result
//  cpu_rsp_ready    in   1       CPU consumes the result
//  cry_req_valid/cry_req_ready/cry_op_a/cry_op_b/cry_alu_ctrl/cry_rsp_valid/cry_rsp_data/cry_rsp_ready
//                   same as cpu_* for the crypto core
//  alu_a, alu_b     out  XLEN    to the shared ALU
//  alu_ctrl         out  CTRL_W  to the shared ALU
//  alu_result       in   XLEN    combinational ALU output
// BEHAVIOUR
//  Reset (rst=1 at edge): rsp_valid=0, rsp_data=0, held operands/ctrl=0 (ADD), starve_cnt=0, state=S_NORM.
//   While rst=1, both req_ready=0. Reset mid-operation discards buffered results and any in-flight accepts.
//  Slot X is free when rsp_valid_X==0 or rsp_ready_X==1 (same-cycle drain+refill, no bubble).
//  Eligible X = req_valid_X && slot X free.
//  Grant, combinational, at most one per cycle:
//   S_NORM:  CPU if eligible, else crypto if eligible.
//   S_FORCE: crypto if eligible, else CPU if eligible (work conserving).
//  req_ready_X = grant_X. ready is never asserted when the slot is blocked.
//  On accept: alu_a/b/ctrl = granted requester's inputs (combinational mux); at the edge rsp_data_X<=alu_result,
//   rsp_valid_X<=1, and held regs <= issued operands/ctrl.
//  No accept: alu_a/b/ctrl = held regs (no toggling).
//  Drain without refill: rsp_valid_X<=0; rsp_data_X keeps its value.
//  starve_cnt: +1 per cycle with cry_req_valid && !cry accept, saturating at MAX_WAIT. Cleared on crypto accept
//   or when cry_req_valid=0.
//  FSM: S_NORM->S_FORCE when starve_cnt==MAX_WAIT. S_FORCE->S_NORM on crypto accept or when cry_req_valid=0.
//   In S_FORCE a blocked crypto slot lets the CPU proceed.
//  Requesters must hold valid and payload until accepted. The block does not check ALUCtrl legality.
// STRUCTURE
//  alu_defs.vh: ALUCtrl constants ADD=0000 SUB=0001 AND=0010 OR=0011 SLT=0101 SLTU=0110 SLL=0111 SRL=1000
//   SRA=1001; FSM encodings S_NORM=1'b0, S_FORCE=1'b1.
//  Sub-module rsp_slot (one-entry result register + valid, drain/refill), instantiated twice.
//  Arbiter, FSM, counter and operand-hold regs live in the top module.
// TESTING (bench uses a behavioural ALU model on alu_*)
//  1 CPU alone: a=5,b=3,ctrl=0000 -> ready same cycle; next cycle cpu_rsp_valid=1, data=8; with rsp_ready=1,
//    valid drops a cycle later.
//  2 Both valid continuously, MAX_WAIT=4, rsp_ready=1: CPU accepted cycles 0-3; crypto forced at cycle 4
//    (cpu_req_ready=0, cry_req_ready=1, crypto a=0xF0 b=0x0F ctrl=0011 -> 0xFF); pattern repeats.
//  3 Backpressure: cpu slot full, cpu_rsp_ready=0, cpu valid -> cpu_req_ready=0; crypto granted; CPU data held stable.
//  4 Drain+refill: cpu slot full, rsp_ready=1, new request SUB 10-4 -> accepted same cycle; next cycle valid=1,
//    data=6, no bubble.
//  5 rst pulsed with both slots full and state S_FORCE -> next cycle rsp_valid=0, state S_NORM, starve_cnt=0,
//    ready=0 during rst.
//  6 Idle 10 cycles after issuing SRA(0x80000000,4) -> alu_a/b/ctrl constant at 0x80000000/4/1001 throughout.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the CPU/crypto ALU share arbiter: ALU operation codes and FSM states.
package alu_share_arbiter_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    // ALUCtrl operation codes understood by the shared ALU
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1001;

    // S_NORM: CPU has priority. S_FORCE: crypto has waited too long and takes priority.
    typedef enum logic {
        S_NORM  = 1'b0,
        S_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_rsp_slot.sv
// One-entry result slot: captures the ALU result on accept, holds it until the requester drains it.
module alu_share_arbiter_rsp_slot #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_data,
    input  logic            i_rsp_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_data,
    output logic            o_free
);

    logic            r_valid;
    logic [XLEN-1:0] r_data;

    // Refill takes precedence over drain so a same-cycle drain+refill leaves no bubble
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    // Slot can accept a new result if empty or being drained this cycle
    assign o_free  = !r_valid || i_rsp_ready;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the CPU execute stage and the crypto core.
// CPU has priority; crypto is forced through after MAX_WAIT consecutive waiting cycles.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CTRL_W   = 4,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // CPU requester
    input  logic              i_cpu_req_valid,
    output logic              o_cpu_req_ready,
    input  logic [XLEN-1:0]   i_cpu_op_a,
    input  logic [XLEN-1:0]   i_cpu_op_b,
    input  logic [CTRL_W-1:0] i_cpu_alu_ctrl,
    output logic              o_cpu_rsp_valid,
    output logic [XLEN-1:0]   o_cpu_rsp_data,
    input  logic              i_cpu_rsp_ready,
    // Crypto requester
    input  logic              i_cry_req_valid,
    output logic              o_cry_req_ready,
    input  logic [XLEN-1:0]   i_cry_op_a,
    input  logic [XLEN-1:0]   i_cry_op_b,
    input  logic [CTRL_W-1:0] i_cry_alu_ctrl,
    output logic              o_cry_rsp_valid,
    output logic [XLEN-1:0]   o_cry_rsp_data,
    input  logic              i_cry_rsp_ready,
    // Shared ALU
    output logic [XLEN-1:0]   o_alu_a,
    output logic [XLEN-1:0]   o_alu_b,
    output logic [CTRL_W-1:0] o_alu_ctrl,
    input  logic [XLEN-1:0]   i_alu_result
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic              w_cpu_free;
    logic              w_cry_free;
    logic              w_cpu_elig;
    logic              w_cry_elig;
    logic              w_cpu_gnt;
    logic              w_cry_gnt;

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [CNT_W-1:0]  w_starve_nxt;

    logic [XLEN-1:0]   r_hold_a;
    logic [XLEN-1:0]   r_hold_b;
    logic [CTRL_W-1:0] r_hold_ctrl;

    assign w_cpu_elig = i_cpu_req_valid && w_cpu_free;
    assign w_cry_elig = i_cry_req_valid && w_cry_free;

    // Grant at most one requester; nothing is granted while reset is asserted
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_cry_gnt = 1'b0;
        if (!i_rst) begin
            unique case (r_state)
                S_NORM: begin
                    if (w_cpu_elig)      w_cpu_gnt = 1'b1;
                    else if (w_cry_elig) w_cry_gnt = 1'b1;
                end
                S_FORCE: begin
                    // A blocked crypto slot lets the CPU through (work conserving)
                    if (w_cry_elig)      w_cry_gnt = 1'b1;
                    else if (w_cpu_elig) w_cpu_gnt = 1'b1;
                end
            endcase
        end
    end

    assign o_cpu_req_ready = w_cpu_gnt;
    assign o_cry_req_ready = w_cry_gnt;

    // Operand mux; when nothing issues the ALU inputs hold their last values to avoid toggling
    always_comb begin
        o_alu_a    = r_hold_a;
        o_alu_b    = r_hold_b;
        o_alu_ctrl = r_hold_ctrl;
        if (w_cpu_gnt) begin
            o_alu_a    = i_cpu_op_a;
            o_alu_b    = i_cpu_op_b;
            o_alu_ctrl = i_cpu_alu_ctrl;
        end else if (w_cry_gnt) begin
            o_alu_a    = i_cry_op_a;
            o_alu_b    = i_cry_op_b;
            o_alu_ctrl = i_cry_alu_ctrl;
        end
    end

    // Starvation counter and priority FSM next-state
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!i_cry_req_valid || w_cry_gnt) begin
            w_starve_nxt = '0;
        end else if (r_starve_cnt != CNT_MAX) begin
            w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end

        w_state_nxt = r_state;
        unique case (r_state)
            // Switch as the count reaches the limit so the forced grant lands on the next cycle
            S_NORM:  if (w_starve_nxt == CNT_MAX) w_state_nxt = S_FORCE;
            S_FORCE: if (w_cry_gnt || !i_cry_req_valid) w_state_nxt = S_NORM;
        endcase
    end

    // State, counter and operand-hold registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_NORM;
            r_starve_cnt <= '0;
            r_hold_a     <= '0;
            r_hold_b     <= '0;
            r_hold_ctrl  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            if (w_cpu_gnt || w_cry_gnt) begin
                r_hold_a    <= o_alu_a;
                r_hold_b    <= o_alu_b;
                r_hold_ctrl <= o_alu_ctrl;
            end
        end
    end

    alu_share_arbiter_rsp_slot #(
        .XLEN (XLEN)
    ) u_cpu_slot (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_cpu_gnt),
        .i_data      (i_alu_result),
        .i_rsp_ready (i_cpu_rsp_ready),
        .o_valid     (o_cpu_rsp_valid),
        .o_data      (o_cpu_rsp_data),
        .o_free      (w_cpu_free)
    );

    alu_share_arbiter_rsp_slot #(
        .XLEN (XLEN)
    ) u_cry_slot (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_cry_gnt),
        .i_data      (i_alu_result),
        .i_rsp_ready (i_cry_rsp_ready),
        .o_valid     (o_cry_rsp_valid),
        .o_data      (o_cry_rsp_data),
        .o_free      (w_cry_free)
    );

endmodule
